// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receive path: FSM state codes,
// default timing thresholds, special ASCII codes and element encoding.
package morse_pkg;

  localparam logic [1:0] ST_WAIT_LOW = 2'd0;
  localparam logic [1:0] ST_SPACE    = 2'd1;
  localparam logic [1:0] ST_MARK     = 2'd2;

  localparam int unsigned DEF_UNIT_CYCLES = 5_000_000;
  localparam int unsigned DEF_DASH_MIN    = 2;
  localparam int unsigned DEF_CHAR_GAP    = 2;
  localparam int unsigned DEF_WORD_GAP    = 5;

  localparam logic [6:0] ASCII_SPACE   = 7'h20;
  localparam logic [6:0] ASCII_UNKNOWN = 7'h3F;

  localparam logic EL_DOT  = 1'b0;
  localparam logic EL_DASH = 1'b1;

endpackage

// File: rtl/morse_symbol_lut.sv
// Combinational Morse symbol lookup: element count plus right-aligned
// element bits (dash=1, first element most significant) to ASCII A-Z, 0-9.
module morse_symbol_lut
  import morse_pkg::*;
(
  input  logic [2:0] sym_len,
  input  logic [4:0] sym_bits,
  output logic [6:0] ascii,
  output logic       hit
);

  // Table lookup keyed on {length, bits}; anything unlisted is a miss
  always_comb begin
    ascii = ASCII_UNKNOWN;
    hit   = 1'b1;
    case ({sym_len, sym_bits})
      8'b001_00000: ascii = 7'h45; // E
      8'b001_00001: ascii = 7'h54; // T
      8'b010_00000: ascii = 7'h49; // I
      8'b010_00001: ascii = 7'h41; // A
      8'b010_00010: ascii = 7'h4E; // N
      8'b010_00011: ascii = 7'h4D; // M
      8'b011_00000: ascii = 7'h53; // S
      8'b011_00001: ascii = 7'h55; // U
      8'b011_00010: ascii = 7'h52; // R
      8'b011_00011: ascii = 7'h57; // W
      8'b011_00100: ascii = 7'h44; // D
      8'b011_00101: ascii = 7'h4B; // K
      8'b011_00110: ascii = 7'h47; // G
      8'b011_00111: ascii = 7'h4F; // O
      8'b100_00000: ascii = 7'h48; // H
      8'b100_00001: ascii = 7'h56; // V
      8'b100_00010: ascii = 7'h46; // F
      8'b100_00100: ascii = 7'h4C; // L
      8'b100_00110: ascii = 7'h50; // P
      8'b100_00111: ascii = 7'h4A; // J
      8'b100_01000: ascii = 7'h42; // B
      8'b100_01001: ascii = 7'h58; // X
      8'b100_01010: ascii = 7'h43; // C
      8'b100_01011: ascii = 7'h59; // Y
      8'b100_01100: ascii = 7'h5A; // Z
      8'b100_01101: ascii = 7'h51; // Q
      8'b101_11111: ascii = 7'h30; // 0
      8'b101_01111: ascii = 7'h31; // 1
      8'b101_00111: ascii = 7'h32; // 2
      8'b101_00011: ascii = 7'h33; // 3
      8'b101_00001: ascii = 7'h34; // 4
      8'b101_00000: ascii = 7'h35; // 5
      8'b101_10000: ascii = 7'h36; // 6
      8'b101_11000: ascii = 7'h37; // 7
      8'b101_11100: ascii = 7'h38; // 8
      8'b101_11110: ascii = 7'h39; // 9
      default:      hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse receiver: synchronises the keyed line, measures mark/space runs in
// time units, assembles dot/dash symbols and emits one ASCII code per
// character plus a space code per word gap.
module morse_rx_decoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = DEF_UNIT_CYCLES,
  parameter int unsigned DASH_MIN    = DEF_DASH_MIN,
  parameter int unsigned CHAR_GAP    = DEF_CHAR_GAP,
  parameter int unsigned WORD_GAP    = DEF_WORD_GAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       morse_in,
  output logic [6:0] ascii_out,
  output logic       ascii_valid,
  output logic       decode_err,
  output logic       busy
);

  localparam int unsigned   CW         = $clog2(UNIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST   = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_HALF   = CW'(UNIT_CYCLES / 2);
  localparam logic [3:0]    DASH_MIN_L = 4'(DASH_MIN);
  localparam logic [2:0]    CHAR_THR   = 3'(CHAR_GAP - 1);
  localparam logic [2:0]    WORD_THR   = 3'(WORD_GAP - 1);

  logic          sync1, sync2, sync3;
  logic          rise, fall, edge_any;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    units;
  logic          tick;
  logic [3:0]    run_len;
  logic [2:0]    sym_len;
  logic [4:0]    sym_bits;
  logic          overflow;
  logic          char_since_space;
  logic          emit_char, emit_word, append, element;
  logic [6:0]    lut_ascii;
  logic          lut_hit;

  // Two-flop synchroniser plus edge-detect stage; reset to "high" so a line
  // held active through reset is not mistaken for a fresh rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= morse_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise     = sync2 & ~sync3;
  assign fall     = ~sync2 & sync3;
  assign edge_any = rise | fall;
  assign tick     = (cnt == CNT_LAST);

  // Run-length timer: restarts on every edge, unit count saturates at 7
  always_ff @(posedge clk) begin
    if (rst || edge_any || state == ST_WAIT_LOW) begin
      cnt   <= '0;
      units <= '0;
    end else if (tick) begin
      cnt <= '0;
      if (units != 3'd7) units <= units + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Threshold events use the pre-edge timer so an edge landing on the
  // char-gap cycle still closes the character before the new mark starts
  always_comb begin
    run_len   = {1'b0, units} + {3'b000, (cnt >= CNT_HALF)};
    element   = (run_len >= DASH_MIN_L) ? EL_DASH : EL_DOT;
    emit_char = (state == ST_SPACE) && tick && (units == CHAR_THR) && (sym_len != 3'd0);
    emit_word = (state == ST_SPACE) && tick && (units == WORD_THR) && char_since_space;
    append    = (state == ST_MARK) && fall && (run_len != 4'd0);
  end

  // Line-state FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_WAIT_LOW;
    end else begin
      case (state)
        ST_WAIT_LOW: if (!sync2) state <= ST_SPACE;
        ST_SPACE:    if (rise)   state <= ST_MARK;
        ST_MARK:     if (fall)   state <= ST_SPACE;
        default:                 state <= ST_WAIT_LOW;
      endcase
    end
  end

  // Symbol buffer: shift elements in at the LSB, flag overflow past five
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_len          <= '0;
      sym_bits         <= '0;
      overflow         <= 1'b0;
      char_since_space <= 1'b0;
    end else if (emit_char) begin
      sym_len          <= '0;
      sym_bits         <= '0;
      overflow         <= 1'b0;
      char_since_space <= 1'b1;
    end else if (emit_word) begin
      char_since_space <= 1'b0;
    end else if (append) begin
      if (sym_len == 3'd5) begin
        overflow <= 1'b1;
      end else begin
        sym_bits <= {sym_bits[3:0], element};
        sym_len  <= sym_len + 3'd1;
      end
    end
  end

  morse_symbol_lut u_lut (
    .sym_len  (sym_len),
    .sym_bits (sym_bits),
    .ascii    (lut_ascii),
    .hit      (lut_hit)
  );

  // Registered character / word-space outputs with one-cycle strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      ascii_out   <= '0;
      ascii_valid <= 1'b0;
      decode_err  <= 1'b0;
    end else begin
      ascii_valid <= 1'b0;
      decode_err  <= 1'b0;
      if (emit_char) begin
        ascii_out   <= (overflow || !lut_hit) ? ASCII_UNKNOWN : lut_ascii;
        ascii_valid <= 1'b1;
        decode_err  <= overflow || !lut_hit;
      end else if (emit_word) begin
        ascii_out   <= ASCII_SPACE;
        ascii_valid <= 1'b1;
      end
    end
  end

  assign busy = (sym_len != 3'd0) || (state == ST_MARK);

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed and randomised bench for morse_rx_decoder using a text-level
// Morse reference (ITU pattern strings) and a strobe capture queue.
module tb_morse_rx_decoder;

  localparam int unsigned U = 8;

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [6:0]  ch;
  } strobe_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       morse_in = 1'b0;
  logic [6:0] ascii_out;
  logic       ascii_valid;
  logic       decode_err;
  logic       busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned t_fall   = 0;
  logic        css      = 1'b0;
  strobe_t     cap_q[$];
  strobe_t     exp_q[$];

  string table_chr = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
  string table_pat[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                           ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                           "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                           "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                           "--...", "---..", "----."};

  morse_rx_decoder #(
    .UNIT_CYCLES (U),
    .DASH_MIN    (2),
    .CHAR_GAP    (2),
    .WORD_GAP    (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .morse_in    (morse_in),
    .ascii_out   (ascii_out),
    .ascii_valid (ascii_valid),
    .decode_err  (decode_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every strobe; an error flag must never appear without a strobe
  always @(negedge clk) begin
    if (!rst) begin
      if (ascii_valid) cap_q.push_back('{cyc: cyc, err: decode_err, ch: ascii_out});
      if (decode_err) check("err_without_valid", {31'd0, ascii_valid}, 32'd1);
    end
  end

  function automatic strobe_t model_char(input string pat);
    strobe_t r;
    r.cyc = 0;
    r.ch  = 7'h3F;
    r.err = 1'b1;
    if (pat.len() <= 5) begin
      for (int i = 0; i < 36; i++) begin
        if (pat == table_pat[i]) begin
          r.ch  = 7'(table_chr[i]);
          r.err = 1'b0;
        end
      end
    end
    return r;
  endfunction

  task automatic expect_char(input string pat);
    exp_q.push_back(model_char(pat));
    css = 1'b1;
  endtask

  task automatic expect_space();
    strobe_t r;
    r.cyc = 0;
    r.ch  = 7'h20;
    r.err = 1'b0;
    if (css) exp_q.push_back(r);
    css = 1'b0;
  endtask

  task automatic drive(input logic v, input int n);
    morse_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Key a pattern; last element is followed by 'gap' cycles of silence
  task automatic send_pat(input string pat, input bit jitter, input int intra, input int gap);
    for (int i = 0; i < pat.len(); i++) begin
      int j1, j2, dur;
      j1  = jitter ? int'($urandom_range(0, 2)) - 1 : 0;
      j2  = jitter ? int'($urandom_range(0, 2)) - 1 : 0;
      dur = (pat[i] == "-") ? 3 * U : U;
      drive(1'b1, dur + j1);
      if (i == pat.len() - 1) begin
        t_fall = cyc;
        drive(1'b0, gap);
      end else begin
        drive(1'b0, intra + j2);
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_ascii"}, {25'd0, cap_q[i].ch}, {25'd0, exp_q[i].ch});
      check({tag, "_err"}, {31'd0, cap_q[i].err}, {31'd0, exp_q[i].err});
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    string pat;
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ascii", {25'd0, ascii_out}, 32'd0);
    check("rst_valid", {31'd0, ascii_valid}, 32'd0);
    check("rst_err", {31'd0, decode_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 10);

    // 'E' then word space, with exact strobe latency from the falling key
    drive(1'b1, 8);
    t_fall = cyc;
    drive(1'b0, 48);
    check("E_strobes", cap_q.size(), 2);
    if (cap_q.size() >= 2) begin
      check("E_delay", cap_q[0].cyc - t_fall, 2 * U + 3);
      check("space_delay", cap_q[1].cyc - t_fall, 5 * U + 3);
    end
    expect_char(".");
    expect_space();
    drain("E");

    // 'A' with busy observed during mark and inter-element gap
    drive(1'b1, 5);
    check("A_busy_mark", {31'd0, busy}, 32'd1);
    drive(1'b1, 3);
    drive(1'b0, 5);
    check("A_busy_gap", {31'd0, busy}, 32'd1);
    drive(1'b0, 3);
    t_fall = 0;
    drive(1'b1, 24);
    drive(1'b0, 16);
    check("A_busy_pre", {31'd0, busy}, 32'd1);
    drive(1'b0, 40);
    expect_char(".-");
    expect_space();
    drain("A");

    // Digits, overflow and an unassigned four-element pattern
    send_pat("-----", 0, U, 7 * U);
    expect_char("-----"); expect_space(); drain("zero");
    send_pat("------", 0, U, 7 * U);
    expect_char("------"); expect_space(); drain("ovf");
    send_pat("..--", 0, U, 7 * U);
    expect_char("..--"); expect_space(); drain("unk");

    // Gap of exactly CHAR_GAP units closes the char on the same cycle the
    // next mark starts; one cycle shorter keeps both dots in one symbol
    send_pat(".", 0, U, 2 * U);
    send_pat(".", 0, U, 7 * U);
    expect_char("."); expect_char("."); expect_space(); drain("gap_eq");
    send_pat(".", 0, U, 2 * U - 1);
    send_pat(".", 0, U, 7 * U);
    expect_char(".."); expect_space(); drain("gap_lt");

    // Saturating long mark decodes as a dash
    drive(1'b1, 60);
    drive(1'b0, 7 * U);
    expect_char("-"); expect_space(); drain("long");

    // Glitch in silence: no element, no strobe, buffer stays empty
    drive(1'b1, 3);
    drive(1'b0, 7 * U);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    drain("glitch");

    // Randomised characters and invalid patterns
    for (int n = 0; n < 30; n++) begin
      bit word;
      if ($urandom_range(0, 3) != 0) begin
        pat = table_pat[$urandom_range(0, 35)];
      end else begin
        int len;
        len = int'($urandom_range(1, 7));
        pat = "";
        for (int k = 0; k < len; k++) pat = {pat, ($urandom_range(0, 1) != 0) ? "-" : "."};
      end
      word = (n == 29) || ($urandom_range(0, 1) != 0);
      send_pat(pat, 1, U, word ? 7 * U : 3 * U);
      expect_char(pat);
      if (word) expect_space();
      drain("rand");
    end

    // Reset during a dash with the line held high
    drive(1'b1, 12);
    rst = 1'b1;
    drive(1'b1, 2);
    @(negedge clk);
    check("mid_rst_ascii", {25'd0, ascii_out}, 32'd0);
    check("mid_rst_valid", {31'd0, ascii_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    css = 1'b0;
    drive(1'b1, 10);
    drive(1'b0, 16);
    check("mid_rst_nostrobe", cap_q.size(), 0);
    send_pat(".", 0, U, 3 * U);
    expect_char(".");
    drain("post_rst");
    drive(1'b0, 4 * U);
    expect_space();
    drain("post_rst_sp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
